// File: rtl/regfile.sv
// Register file with two asynchronous read ports and one synchronous write port.
// x0 is hardwired to zero. A same-cycle write is bypassed to any matching read port.
module regfile #(
    parameter int DATA_WIDTH = 32,
    localparam int REG_BUS_WIDTH = $clog2(DATA_WIDTH),
    localparam int NUM_REGS = 2 ** REG_BUS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_BUS_WIDTH-1:0] rs1,
    input  logic [REG_BUS_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0]    rs1_data,
    output logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     write_enable,
    input  logic [REG_BUS_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  bypass;

    // NOTE: every entry is reset because contents must read zero after reset;
    // this keeps the array in flops rather than letting it map to a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: sequential state uses non-blocking assignment so every
                // flop samples pre-edge values regardless of statement order.
                regs[i] <= '0;
            end
        end else if (write_enable && rd != '0) begin
            regs[rd] <= rd_data;
        end
    end

    assign bypass = write_enable && !rst && (rd != '0);

    // Priority: reset/x0 force zero, then write-through, then stored value.
    always_comb begin
        // NOTE: outputs get an unconditional default first so no path leaves
        // them unassigned, which would otherwise infer a latch.
        rs1_data = regs[rs1];
        rs2_data = regs[rs2];
        if (bypass && rd == rs1) rs1_data = rd_data;
        if (bypass && rd == rs2) rs2_data = rd_data;
        if (rst || rs1 == '0) rs1_data = '0;
        if (rst || rs2 == '0) rs2_data = '0;
    end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus queues expected read values, a monitor
// on the falling edge pops and compares them against the live read ports.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        write_enable = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] rd_data = '0;

    int checks = 0;
    int errors = 0;

    string       q_name [$];
    bit          q_port [$];
    logic [31:0] q_exp  [$];

    logic [31:0] model [32];

    regfile #(.DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .rs1(rs1),
        .rs2(rs2),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .write_enable(write_enable),
        .rd(rd),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Monitor: reads are combinational, so the outputs are valid mid-cycle.
    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            string       n;
            bit          p;
            logic [31:0] e;
            logic [31:0] a;
            n = q_name.pop_front();
            p = q_port.pop_front();
            e = q_exp.pop_front();
            a = p ? rs2_data : rs1_data;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s rs%0d_data: got %08h expected %08h at %0t",
                         n, p ? 2 : 1, a, e, $time);
            end
        end
    end

    task automatic drive(input logic r, input logic we, input logic [4:0] w_rd,
                         input logic [31:0] w_data, input logic [4:0] a1,
                         input logic [4:0] a2);
        @(posedge clk);
        #1;
        rst          = r;
        write_enable = we;
        rd           = w_rd;
        rd_data      = w_data;
        rs1          = a1;
        rs2          = a2;
    endtask

    task automatic expect_rd(input string n, input bit p, input logic [31:0] e);
        q_name.push_back(n);
        q_port.push_back(p);
        q_exp.push_back(e);
    endtask

    // Reads every register through both ports against the bench's own model.
    task automatic sweep(input string n);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            expect_rd(n, 1'b0, model[i]);
            expect_rd(n, 1'b1, model[31 - i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  r;
        logic [31:0] d;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset for two clocks with a would-be bypass write: ports must read 0.
        drive(1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd3);
        expect_rd("rst_bypass_off", 1'b0, 32'h0);
        expect_rd("rst_bypass_off", 1'b1, 32'h0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd17, 5'd31);
        expect_rd("rst_read_zero", 1'b0, 32'h0);
        expect_rd("rst_read_zero", 1'b1, 32'h0);

        sweep("post_reset_zero");

        // Write x5, then read on both ports next cycle.
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
        expect_rd("x1_untouched", 1'b0, 32'h0);
        expect_rd("x2_untouched", 1'b1, 32'h0);
        model[5] = 32'hDEADBEEF;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        expect_rd("x5_read", 1'b0, 32'hDEADBEEF);
        expect_rd("x5_read", 1'b1, 32'hDEADBEEF);

        // Write to x0 is discarded and not bypassed.
        drive(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        expect_rd("x0_no_bypass", 1'b0, 32'h0);
        expect_rd("x0_no_bypass", 1'b1, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
        expect_rd("x0_after_write", 1'b0, 32'h0);
        expect_rd("x5_keep", 1'b1, 32'hDEADBEEF);

        // write_enable low: no write, no bypass.
        drive(1'b0, 1'b0, 5'd5, 32'hFFFFFFFF, 5'd5, 5'd6);
        expect_rd("we0_no_bypass", 1'b0, 32'hDEADBEEF);
        expect_rd("we0_x6", 1'b1, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        expect_rd("we0_no_write", 1'b0, 32'hDEADBEEF);

        // Bypass on x7 in the write cycle, then committed value after the edge.
        drive(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5);
        expect_rd("bypass_x7", 1'b0, 32'hA5A5A5A5);
        expect_rd("bypass_other", 1'b1, 32'hDEADBEEF);
        model[7] = 32'hA5A5A5A5;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
        expect_rd("x7_commit", 1'b1, 32'hA5A5A5A5);

        // Overwrite x7 while rs1 reads x5: independent ports, bypass on rs2 only.
        drive(1'b0, 1'b1, 5'd7, 32'h0F0F0F0F, 5'd5, 5'd7);
        expect_rd("indep_rs1", 1'b0, 32'hDEADBEEF);
        expect_rd("indep_rs2_byp", 1'b1, 32'h0F0F0F0F);
        model[7] = 32'h0F0F0F0F;

        // Ten write-then-read pairs; pair 3 targets x0.
        for (int k = 0; k < 10; k++) begin
            r = (k == 3) ? 5'd0 : 5'($urandom_range(31, 0));
            d = $urandom;
            drive(1'b0, 1'b1, r, d, 5'd0, r);
            expect_rd("rand_bypass", 1'b1, (r == 5'd0) ? 32'h0 : d);
            if (r != 5'd0) model[r] = d;
            drive(1'b0, 1'b0, 5'd0, 32'h0, r, 5'd0);
            expect_rd("rand_read", 1'b0, (r == 5'd0) ? 32'h0 : d);
        end

        sweep("model_match");

        // Reset has priority over a concurrent write.
        drive(1'b0, 1'b1, 5'd3, 32'h00000001, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 5'd4, 32'h00000002, 5'd3, 5'd4);
        expect_rd("rst_prio_x3", 1'b0, 32'h0);
        expect_rd("rst_prio_x4", 1'b1, 32'h0);
        for (int i = 0; i < 32; i++) model[i] = '0;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        expect_rd("after_rst_x3", 1'b0, 32'h0);
        expect_rd("after_rst_x4", 1'b1, 32'h0);

        sweep("post_reset2_zero");

        // First write after reset is a normal write.
        drive(1'b0, 1'b1, 5'd31, 32'h55AA55AA, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
        expect_rd("first_write", 1'b0, 32'h55AA55AA);
        expect_rd("first_write", 1'b1, 32'h55AA55AA);

        @(negedge clk);
        #1;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each register and data port.
REQ-002 SHALL have derived localparam REG_BUS_WIDTH = $clog2(DATA_WIDTH), 5 at default: register address width; register count NUM_REGS = 2**REG_BUS_WIDTH, 32 at default.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-006 rs1  input  REG_BUS_WIDTH  read port 1 address.
REQ-007 rs2  input  REG_BUS_WIDTH  read port 2 address.
REQ-008 rs1_data  output  DATA_WIDTH  read port 1 data, combinational.
REQ-009 rs2_data  output  DATA_WIDTH  read port 2 data, combinational.
REQ-010 write_enable  input  1  write strobe, sampled on rising clk.
REQ-011 rd  input  REG_BUS_WIDTH  write address.
REQ-012 rd_data  input  DATA_WIDTH  write data.

Function
REQ-013 SHALL hold NUM_REGS registers x0..x(NUM_REGS-1), each DATA_WIDTH bits.
REQ-014 Reads SHALL be asynchronous: rsN_data reflects the addressed register within the same cycle, with no clock latency, and follows any change of rsN combinationally.
REQ-015 x0 SHALL always read as 0 on both ports, regardless of any prior write.
REQ-016 Writes SHALL occur on rising clk when write_enable=1 and rst=0: reg[rd] <= rd_data; 1-cycle write latency.
REQ-017 A write with rd=0 SHALL be discarded, with no side effect on any register.
REQ-018 write_enable=0 SHALL leave all registers unchanged.
REQ-019 Write-through bypass: while write_enable=1, rst=0 and rd!=0, a port whose address equals rd SHALL output rd_data combinationally in that same cycle.
REQ-020 Bypass SHALL NOT apply when rd=0; x0 stays 0.
REQ-021 Both read ports SHALL be independent: same or different addresses, simultaneously, with no conflict.
REQ-022 Simultaneous read and write of the same address without bypass conditions SHALL return the old value until the clock edge commits the write.
REQ-023 No arithmetic is performed; data SHALL pass bit-exact at full DATA_WIDTH.

Reset
REQ-024 When rst=1 at rising clk, all registers SHALL clear to 0; reset has priority over a concurrent write.
REQ-025 While rst=1, both read ports SHALL output 0, and bypass SHALL be suppressed.
REQ-026 Reset asserted mid-operation SHALL discard any pending write in that cycle; contents after reset SHALL be all-zero.
REQ-027 After rst deasserts, the first rising clk with write_enable=1 SHALL perform a normal write.

Verification
REQ-028 Hold rst=1 for 2 clocks, release, then sweep rs1 and rs2 over 0..31 -> every read = 0x00000000.
REQ-029 Write rd=5, rd_data=0xDEADBEEF; next cycle rs1=5 and rs2=5 -> both ports = 0xDEADBEEF.
REQ-030 Write rd=0, rd_data=0x12345678; read rs1=0 -> 0x00000000, with no other register changed.
REQ-031 With write_enable=1, rd=7, rd_data=0xA5A5A5A5 and rs1=7 before the edge -> rs1_data=0xA5A5A5A5 in the same cycle (bypass); rs2=7 after the edge -> 0xA5A5A5A5.
REQ-032 Ten random (rd in 0..31, random data) write-then-read-via-rs1 pairs -> read = written data, or 0 when rd=0.
REQ-033 Write x3=0x1; assert rst together with a write of x4=0x2 -> after reset x3=0 and x4=0.
